// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: a DEPTH-entry circular buffer with valid/ready on both
// sides, synchronous flush for squash, occupancy count and a registered drop pulse.
module pipe_stage_elastic #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              drop_o
);

    localparam int               PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(DEPTH - 1);

    // Explicit compare keeps the wrap correct for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR_C) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [DATA_W-1:0] storage_r [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              drop_r;

    logic              ready_s;
    logic              valid_s;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic [CNT_W-1:0]  count_nxt_s;
    logic [DATA_W-1:0] data_s;

    // Handshake decode; ready depends only on the registered count.
    always_comb begin
        ready_s = (count_r < DEPTH_C);
        valid_s = (count_r != {CNT_W{1'b0}}) && !flush_i;
        push_s  = valid_i && ready_s && !flush_i;
        pop_s   = valid_s && ready_i;
        drop_s  = valid_i && !ready_s && !flush_i;
    end

    // Occupancy update: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Head payload, masked to zero whenever nothing is presented.
    always_comb begin
        data_s = {DATA_W{1'b0}};
        if (valid_s) begin
            data_s = storage_r[rd_ptr_r];
        end else begin
            data_s = {DATA_W{1'b0}};
        end
    end

    // Pointer, count and drop state; reset outranks flush, flush outranks handshakes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            drop_r   <= 1'b0;
        end else if (flush_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            drop_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_nxt_s;
            drop_r  <= drop_s;
        end
    end

    // Payload storage; flush leaves contents in place since data_o masks them.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            storage_r[wr_ptr_r] <= data_i;
        end
    end

    assign ready_o = ready_s;
    assign valid_o = valid_s;
    assign data_o  = data_s;
    assign count_o = count_r;
    assign drop_o  = drop_r;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench: three stages (DEPTH 2, 3, 4) share one stimulus stream; each
// has a queue-based reference model and a negedge monitor comparing the DUT to it.
module tb_pipe_stage_elastic;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [63:0] dat;
    logic        chk_en = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s depth=%0d t=%0t got=%h expected=%h", name, d, $time, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_stage
        localparam int D = g + 2;
        localparam int CW = $clog2(D + 1);

        logic          ready_o;
        logic          valid_o;
        logic [63:0]   data_o;
        logic [CW-1:0] count_o;
        logic          drop_o;

        pipe_stage_elastic #(.DATA_W(64), .DEPTH(D)) dut (
            .clk_i  (clk),
            .reset_i(rst),
            .flush_i(flush),
            .valid_i(vld),
            .ready_o(ready_o),
            .data_i (dat),
            .valid_o(valid_o),
            .ready_i(rdy),
            .data_o (data_o),
            .count_o(count_o),
            .drop_o (drop_o)
        );

        // Reference model: a plain FIFO queue, bounded at D entries.
        logic [63:0] mq [$];
        logic        exp_drop = 1'b0;
        int          sz;

        always @(posedge clk) begin
            if (rst) begin
                mq.delete();
                exp_drop <= 1'b0;
            end else begin
                sz = mq.size();
                exp_drop <= vld && (sz >= D) && !flush;
                if (flush) begin
                    mq.delete();
                end else begin
                    if (sz != 0 && rdy) void'(mq.pop_front());
                    if (vld && sz < D) mq.push_back(dat);
                end
            end
        end

        // Monitor: compare presented outputs against the model mid-cycle.
        always @(negedge clk) begin
            if (chk_en) begin
                check("ready", D, {63'd0, ready_o}, {63'd0, mq.size() < D});
                check("count", D, 64'(count_o), 64'(mq.size()));
                check("count_bound", D, {63'd0, int'(count_o) <= D}, 64'd1);
                check("drop", D, {63'd0, drop_o}, {63'd0, exp_drop});
                check("valid", D, {63'd0, valid_o}, {63'd0, (mq.size() != 0) && !flush});
                if (mq.size() != 0 && !flush) begin
                    check(rdy ? "data_pop" : "data_head", D, data_o, mq[0]);
                end else begin
                    check("data_masked", D, data_o, 64'd0);
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic r,
                       input logic f, input logic rs);
        vld   = v;
        dat   = d;
        rdy   = r;
        flush = f;
        rst   = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vld = 1'b0; dat = 64'd0; rdy = 1'b0; flush = 1'b0; rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Stream 1,2,3 with the consumer always ready.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Backpressure fill, overflow pushes, then drain.
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hA4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hA4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Full with simultaneous pop and push attempt.
        for (int i = 0; i < 4; i++) cyc(1'b1, 64'hB0 + 64'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hB5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 64'hB6, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Flush with in-flight data and a colliding push.
        for (int i = 0; i < 3; i++) cyc(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hFF, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 64'hC3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Wrap-around: 0x10..0x19 with random consumer readiness.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 64'h10 + 64'(i), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 64'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 59) == 0));
        end

        // Reset mid-operation with a drop pending.
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'hD0 + 64'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 64'hDF, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 64'hE0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
